// File: rtl/mem_port_pkg.sv
// ============================================================================
//  Module      : rv32i_types (package)
//  Description : Shared RV32I memory-access types: access size and
//                memory-port controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

    typedef enum logic [1:0] {
        MEM_BYTE    = 2'b00,
        MEM_HALF    = 2'b01,
        MEM_WORD    = 2'b10,
        MEM_ILLEGAL = 2'b11
    } mem_size_t;

    typedef enum logic [2:0] {
        MP_IDLE = 3'd0,
        MP_REQ  = 3'd1,
        MP_WAIT = 3'd2,
        MP_DONE = 3'd3,
        MP_ERR  = 3'd4
    } memport_state_t;

    localparam logic [3:0] C_BE_NONE = 4'b0000;
    localparam logic [3:0] C_BE_ALL  = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/mem_port_byte_en_gen.sv
// ============================================================================
//  Module      : byte_en_gen
//  Description : Lane mask and alignment check for an access of a given size
//                at a given byte offset within a word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_en_gen
    import rv32i_types::*;
(
    input  mem_size_t   i_size,
    input  logic [1:0]  i_addr,
    output logic [3:0]  o_be,
    output logic        o_misaligned
);

    always_comb begin
        o_be         = C_BE_NONE;
        o_misaligned = 1'b0;
        case (i_size)
            MEM_BYTE: begin
                o_be = 4'b0001 << i_addr;
            end
            MEM_HALF: begin
                o_be         = i_addr[1] ? 4'b1100 : 4'b0011;
                o_misaligned = i_addr[0];
            end
            MEM_WORD: begin
                o_be         = C_BE_ALL;
                o_misaligned = |i_addr;
            end
            // An illegal size is reported through the same error path.
            default: begin
                o_be         = C_BE_NONE;
                o_misaligned = 1'b1;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_port.sv
// ============================================================================
//  Module      : mem_port
//  Description : Memory-port controller between the RV32I multicycle core and
//                a valid/ready memory bus, with alignment and timeout errors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port
    import rv32i_types::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr_unaligned,
    input  logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata
);

    localparam int              CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    memport_state_t     state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bus_req_valid_q, bus_req_valid_d;
    logic               bus_we_q, bus_we_d;
    logic [31:0]        bus_addr_q, bus_addr_d;
    logic [31:0]        bus_wdata_q, bus_wdata_d;
    logic [3:0]         bus_be_q, bus_be_d;
    logic               mem_resp_q, mem_resp_d;
    logic               mem_err_q, mem_err_d;
    logic [31:0]        mem_rdata_q, mem_rdata_d;

    logic [3:0]         w_be;
    logic               w_misaligned;

    byte_en_gen u_byte_en_gen (
        .i_size       (mem_size_t'(mem_size)),
        .i_addr       (mem_addr_unaligned[1:0]),
        .o_be         (w_be),
        .o_misaligned (w_misaligned)
    );

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bus_req_valid_d = 1'b0;
        bus_we_d        = bus_we_q;
        bus_addr_d      = bus_addr_q;
        bus_wdata_d     = bus_wdata_q;
        bus_be_d        = bus_be_q;
        mem_resp_d      = 1'b0;
        mem_err_d       = 1'b0;
        mem_rdata_d     = mem_rdata_q;

        case (state_q)
            MP_IDLE: begin
                if (mem_read || mem_write) begin
                    bus_we_d    = mem_write;
                    bus_addr_d  = {mem_addr_unaligned[31:2], 2'b00};
                    bus_wdata_d = mem_wdata;
                    bus_be_d    = w_be;
                    if (w_misaligned || (mem_read && mem_write)) begin
                        state_d    = MP_ERR;
                        mem_resp_d = 1'b1;
                        mem_err_d  = 1'b1;
                    end else begin
                        state_d         = MP_REQ;
                        bus_req_valid_d = 1'b1;
                    end
                end
            end
            MP_REQ: begin
                if (bus_req_ready) begin
                    state_d = MP_WAIT;
                    cnt_d   = '0;
                end else begin
                    bus_req_valid_d = 1'b1;
                end
            end
            MP_WAIT: begin
                // A response arriving on the last counted cycle still wins.
                if (bus_rsp_valid) begin
                    state_d    = MP_DONE;
                    mem_resp_d = 1'b1;
                    if (!bus_we_q) begin
                        mem_rdata_d = bus_rsp_rdata;
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d    = MP_DONE;
                    mem_resp_d = 1'b1;
                    mem_err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            MP_DONE: state_d = MP_IDLE;
            MP_ERR:  state_d = MP_IDLE;
            default: state_d = MP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= MP_IDLE;
            cnt_q           <= '0;
            bus_req_valid_q <= 1'b0;
            bus_we_q        <= 1'b0;
            bus_addr_q      <= '0;
            bus_wdata_q     <= '0;
            bus_be_q        <= '0;
            mem_resp_q      <= 1'b0;
            mem_err_q       <= 1'b0;
            mem_rdata_q     <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bus_req_valid_q <= bus_req_valid_d;
            bus_we_q        <= bus_we_d;
            bus_addr_q      <= bus_addr_d;
            bus_wdata_q     <= bus_wdata_d;
            bus_be_q        <= bus_be_d;
            mem_resp_q      <= mem_resp_d;
            mem_err_q       <= mem_err_d;
            mem_rdata_q     <= mem_rdata_d;
        end
    end

    assign mem_byte_enable = w_be;
    assign mem_resp        = mem_resp_q;
    assign mem_err         = mem_err_q;
    assign mem_rdata       = mem_rdata_q;
    assign bus_req_valid   = bus_req_valid_q;
    assign bus_we          = bus_we_q;
    assign bus_addr        = bus_addr_q;
    assign bus_wdata       = bus_wdata_q;
    assign bus_be          = bus_be_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port.sv
// ============================================================================
//  Module      : tb_mem_port
//  Description : Self-checking bench for mem_port with a directed bus model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr_unaligned, mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp, mem_err;
    logic [31:0] mem_rdata;
    logic        bus_req_valid, bus_req_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;

    int checks   = 0;
    int failures = 0;

    mem_port #(.TIMEOUT(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_size           (mem_size),
        .mem_addr_unaligned (mem_addr_unaligned),
        .mem_wdata          (mem_wdata),
        .mem_byte_enable    (mem_byte_enable),
        .mem_resp           (mem_resp),
        .mem_rdata          (mem_rdata),
        .mem_err            (mem_err),
        .bus_req_valid      (bus_req_valid),
        .bus_req_ready      (bus_req_ready),
        .bus_we             (bus_we),
        .bus_addr           (bus_addr),
        .bus_wdata          (bus_wdata),
        .bus_be             (bus_be),
        .bus_rsp_valid      (bus_rsp_valid),
        .bus_rsp_rdata      (bus_rsp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rsp;
        logic [3:0]  be;
        int          resp_cyc;
        logic        err;
        logic [31:0] rdata;
        int          vcyc;
        logic [31:0] baddr;
        logic        we;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one control request and plays the bus side; cycle 1 is the
    // first cycle after the request is sampled.
    task automatic run_access(
        input  logic        rd,
        input  logic        wr,
        input  logic [1:0]  sz,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  int          rdy_delay,
        input  int          rsp_delay,
        input  bit          respond,
        input  logic [31:0] rsp_data,
        output logic [3:0]  comb_be,
        output int          resp_cyc,
        output int          resp_cnt,
        output logic        err,
        output logic [31:0] rdata,
        output int          vcyc,
        output bit          stable,
        output logic [31:0] q_addr,
        output logic [3:0]  q_be,
        output logic        q_we,
        output logic [31:0] q_wdata
    );
        int acc;
        acc = -1; resp_cyc = -1; resp_cnt = 0; err = 1'b0; rdata = '0;
        vcyc = 0; stable = 1'b1; q_addr = '0; q_be = '0; q_we = 1'b0; q_wdata = '0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_size = sz;
        mem_addr_unaligned = addr; mem_wdata = wdata;
        #1 comb_be = mem_byte_enable;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
            if (mem_resp) begin
                resp_cnt++;
                if (resp_cyc < 0) begin
                    resp_cyc = cyc; err = mem_err; rdata = mem_rdata;
                end
                mem_read = 1'b0; mem_write = 1'b0;
            end
            if (bus_req_valid) begin
                vcyc++;
                if (vcyc == 1) begin
                    q_addr = bus_addr; q_be = bus_be; q_we = bus_we; q_wdata = bus_wdata;
                end else if (bus_addr !== q_addr || bus_be !== q_be ||
                             bus_we !== q_we || bus_wdata !== q_wdata) begin
                    stable = 1'b0;
                end
                if (vcyc > rdy_delay) begin
                    bus_req_ready = 1'b1;
                    acc = cyc;
                end
            end
            if (respond && acc >= 0 && cyc == acc + rsp_delay) begin
                bus_rsp_valid = 1'b1; bus_rsp_rdata = rsp_data;
            end
            if (resp_cyc >= 0 && cyc >= resp_cyc + 3) break;
        end
        mem_read = 1'b0; mem_write = 1'b0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
    endtask

    logic [3:0]  o_cbe, o_be;
    int          o_rc, o_rn, o_vc;
    logic        o_err, o_we;
    logic [31:0] o_rd, o_addr, o_wd;
    bit          o_st;

    initial begin
        //            rd    wr    sz     addr          wdata         rsp           be       rc err  rdata         vc baddr         we
        vecs[0] = '{1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 4'b1111, 3, 1'b0, 32'hDEAD_BEEF, 1, 32'h0000_0100, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 2'b00, 32'h0000_0203, 32'hAB00_0000, 32'h1234_5678, 4'b1000, 3, 1'b0, 32'hDEAD_BEEF, 1, 32'h0000_0200, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 2'b01, 32'h0000_0101, 32'h0,        32'h0,         4'b0011, 1, 1'b1, 32'hDEAD_BEEF, 0, 32'h0,         1'b0};
        vecs[3] = '{1'b1, 1'b1, 2'b10, 32'h0000_0100, 32'h0,        32'h0,         4'b1111, 1, 1'b1, 32'hDEAD_BEEF, 0, 32'h0,         1'b0};
        vecs[4] = '{1'b1, 1'b0, 2'b10, 32'h0000_0102, 32'h0,        32'h0,         4'b1111, 1, 1'b1, 32'hDEAD_BEEF, 0, 32'h0,         1'b0};
        vecs[5] = '{1'b1, 1'b0, 2'b11, 32'h0000_0000, 32'h0,        32'h0,         4'b0000, 1, 1'b1, 32'hDEAD_BEEF, 0, 32'h0,         1'b0};
        vecs[6] = '{1'b1, 1'b0, 2'b01, 32'h0000_0346, 32'h0,        32'hCAFE_0000, 4'b1100, 3, 1'b0, 32'hCAFE_0000, 1, 32'h0000_0344, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 2'b00, 32'h0000_0001, 32'h0,        32'h1122_3344, 4'b0010, 3, 1'b0, 32'h1122_3344, 1, 32'h0000_0000, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 2'b01, 32'h0000_0010, 32'h0000_5566, 32'h9999_9999, 4'b0011, 3, 1'b0, 32'h1122_3344, 1, 32'h0000_0010, 1'b1};

        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'b00;
        mem_addr_unaligned = '0; mem_wdata = '0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_resp",  {31'b0, mem_resp}, 32'h0);
        check("rst_err",   {31'b0, mem_err}, 32'h0);
        check("rst_valid", {31'b0, bus_req_valid}, 32'h0);
        check("rst_addr",  bus_addr, 32'h0);
        check("rst_be",    {28'b0, bus_be}, 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_access(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wdata,
                       0, 1, 1'b1, vecs[i].rsp,
                       o_cbe, o_rc, o_rn, o_err, o_rd, o_vc, o_st, o_addr, o_be, o_we, o_wd);
            check($sformatf("v%0d_mem_be", i), {28'b0, o_cbe}, {28'b0, vecs[i].be});
            check($sformatf("v%0d_resp_cyc", i), o_rc, vecs[i].resp_cyc);
            check($sformatf("v%0d_resp_cnt", i), o_rn, 1);
            check($sformatf("v%0d_err", i), {31'b0, o_err}, {31'b0, vecs[i].err});
            check($sformatf("v%0d_rdata", i), o_rd, vecs[i].rdata);
            check($sformatf("v%0d_valid_cyc", i), o_vc, vecs[i].vcyc);
            if (vecs[i].vcyc > 0) begin
                check($sformatf("v%0d_bus_addr", i), o_addr, vecs[i].baddr);
                check($sformatf("v%0d_bus_be", i), {28'b0, o_be}, {28'b0, vecs[i].be});
                check($sformatf("v%0d_bus_we", i), {31'b0, o_we}, {31'b0, vecs[i].we});
                check($sformatf("v%0d_bus_wdata", i), o_wd, vecs[i].wdata);
            end
        end

        // Ready held low for 5 request cycles, response 3 cycles after acceptance.
        run_access(1'b0, 1'b1, 2'b10, 32'h0000_0400, 32'h0102_0304, 5, 3, 1'b1, 32'h7777_7777,
                   o_cbe, o_rc, o_rn, o_err, o_rd, o_vc, o_st, o_addr, o_be, o_we, o_wd);
        check("stall_valid_cyc", o_vc, 6);
        check("stall_stable", {31'b0, o_st}, 32'h1);
        check("stall_addr", o_addr, 32'h0000_0400);
        check("stall_wdata", o_wd, 32'h0102_0304);
        check("stall_resp_cyc", o_rc, 10);
        check("stall_resp_cnt", o_rn, 1);
        check("stall_err", {31'b0, o_err}, 32'h0);
        check("stall_rdata", o_rd, 32'h1122_3344);

        // No response: WAIT entered in cycle 2, timeout response in cycle 7.
        run_access(1'b1, 1'b0, 2'b10, 32'h0000_0500, 32'h0, 0, 1, 1'b0, 32'h0,
                   o_cbe, o_rc, o_rn, o_err, o_rd, o_vc, o_st, o_addr, o_be, o_we, o_wd);
        check("to_resp_cyc", o_rc, 7);
        check("to_resp_cnt", o_rn, 1);
        check("to_err", {31'b0, o_err}, 32'h1);
        check("to_rdata", o_rd, 32'h1122_3344);

        run_access(1'b1, 1'b0, 2'b10, 32'h0000_0600, 32'h0, 0, 1, 1'b1, 32'h0BAD_F00D,
                   o_cbe, o_rc, o_rn, o_err, o_rd, o_vc, o_st, o_addr, o_be, o_we, o_wd);
        check("after_to_resp_cyc", o_rc, 3);
        check("after_to_err", {31'b0, o_err}, 32'h0);
        check("after_to_rdata", o_rd, 32'h0BAD_F00D);

        // Reset asserted while waiting for a response.
        @(negedge clk);
        mem_read = 1'b1; mem_size = 2'b10; mem_addr_unaligned = 32'h0000_0700; mem_wdata = 32'h0;
        @(negedge clk);
        check("mid_valid", {31'b0, bus_req_valid}, 32'h1);
        check("mid_addr", bus_addr, 32'h0000_0700);
        bus_req_ready = 1'b1;
        @(negedge clk);
        bus_req_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("arst_valid", {31'b0, bus_req_valid}, 32'h0);
        check("arst_addr", bus_addr, 32'h0);
        check("arst_be", {28'b0, bus_be}, 32'h0);
        check("arst_resp", {31'b0, mem_resp}, 32'h0);
        check("arst_rdata", mem_rdata, 32'h0);
        mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_access(1'b1, 1'b0, 2'b10, 32'h0000_0104, 32'h0, 0, 1, 1'b1, 32'h55AA_55AA,
                   o_cbe, o_rc, o_rn, o_err, o_rd, o_vc, o_st, o_addr, o_be, o_we, o_wd);
        check("post_rst_resp_cyc", o_rc, 3);
        check("post_rst_err", {31'b0, o_err}, 32'h0);
        check("post_rst_rdata", o_rd, 32'h55AA_55AA);
        check("post_rst_addr", o_addr, 32'h0000_0104);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port.md
# mem_port

Memory-port controller that sits directly downstream of the RV32I multicycle datapath and its control FSM, between them and the physical memory bus. It takes the control unit's level-held `mem_read`/`mem_write` request, the datapath's unaligned address and lane-shifted write data, and generates the byte enables. It runs one valid/ready request plus response transaction on the bus, then returns a one-cycle `mem_resp` with read data. Misaligned accesses and bus timeouts are reported via `mem_err` instead of hanging the core.

## Interface
- `TIMEOUT`, default 255: maximum cycles spent in WAIT before the access is aborted with an error.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_read` in 1: read request from control; held high until `mem_resp`.
- `mem_write` in 1: write request from control; held high until `mem_resp`.
- `mem_size` in 2: `mem_size_t` access size: byte=00, half=01, word=10, 11=illegal.
- `mem_addr_unaligned` in 32: byte address from the datapath MAR.
- `mem_wdata` in 32: write data, already shifted into its lanes by the datapath.
- `mem_byte_enable` out 4: combinational lane mask from the current `mem_size`/address; feeds the datapath `read_mask`/`write_mask`.
- `mem_resp` out 1: one-cycle completion pulse.
- `mem_rdata` out 32: read data; valid with `mem_resp`, held until the next read completes.
- `mem_err` out 1: valid only with `mem_resp`; 1 = misaligned, illegal size, both requests set, or timeout.
- `bus_req_valid` out 1 / `bus_req_ready` in 1: request handshake.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `bus_wdata` out 32: write data.
- `bus_be` out 4: byte enables.
- `bus_rsp_valid` in 1: response strobe; one per accepted request, reads and writes alike.
- `bus_rsp_rdata` in 32: response read data.

## Operation
- Byte enable per `mem_size` and `a = addr[1:0]`:
  - byte: `4'b0001 << a`.
  - half: `a[1] ? 4'b1100 : 4'b0011`; misaligned if `a[0]=1`.
  - word: `4'b1111`; misaligned if `a != 0`.
  - size 11: `4'b0000` and error.
- FSM states: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - `mem_read|mem_write` sampled high starts an access; latch `bus_addr`, `bus_wdata`, `bus_be` and `bus_we` (= `mem_write`).
  - Go to ERR if the access is misaligned, the size is illegal, or both `mem_read` and `mem_write` are high. Otherwise go to REQ.
- REQ: `bus_req_valid=1` with all bus fields stable; on `bus_req_ready=1` go to WAIT and clear the timeout counter.
- WAIT:
  - `bus_rsp_valid=1` → DONE; capture `bus_rsp_rdata` into `mem_rdata` only for reads.
  - Counter reaching `TIMEOUT` without a response → DONE with the error flag set; `mem_rdata` unchanged.
- DONE: `mem_resp=1` for one cycle, with `mem_err` = the timeout flag; next state IDLE.
- ERR: `mem_resp=1` and `mem_err=1` for one cycle; no bus transaction; next state IDLE.
- Control contract: control drops the request in the cycle after `mem_resp`. A request still high in IDLE is treated as a new access.
- `bus_rsp_valid` outside WAIT is ignored. The bus guarantees no response later than TIMEOUT cycles and none in the same cycle the request is accepted.

## Timing
- Reset (async assert, sync deassert at the core level):
  - State IDLE; counter and error flag 0.
  - `bus_req_valid`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_be`, `mem_resp`, `mem_err`, `mem_rdata` all 0.
- Reset mid-access: state returns to IDLE immediately and the in-flight bus transaction is abandoned. The bus is reset by the same `rst`.
- All outputs except `mem_byte_enable` are registered.
- Minimum latency with zero-wait memory:
  - Cycle 0: request sampled.
  - Cycle 1: REQ, accepted.
  - Cycle 2: WAIT, response.
  - Cycle 3: `mem_resp`.
- Error latency: `mem_resp` in cycle 1.
- Stalls: `bus_req_valid` stays high through any number of `bus_req_ready=0` cycles. REQ does not time out.
- Counter width `$clog2(TIMEOUT+1)`. Timeout fires when the count reaches `TIMEOUT` in WAIT, giving `mem_resp` `TIMEOUT+1` cycles after entering WAIT.

## Structure
- Add to `rv32i_types`: `mem_size_t` enum and `memport_state_t` enum.
- One combinational sub-module, `byte_en_gen` (size, addr[1:0] → be[3:0], misaligned). It is reused by the datapath lane logic.
- FSM, counter and registers live in `mem_port`.

## Test plan
- Word read at 0x100, ready=1, response 1 cycle later with 0xDEADBEEF → `bus_addr=0x100`, `be=1111`, `mem_resp` in cycle 3, `mem_rdata=0xDEADBEEF`, `mem_err=0`.
- Byte write at 0x203, `wdata=0xAB000000` → `bus_be=1000`, `bus_we=1`, `bus_addr=0x200`; `mem_rdata` unchanged.
- Half read at 0x101 → ERR, `mem_resp=mem_err=1` in cycle 1, `bus_req_valid` never asserted; `mem_read`+`mem_write` both high behaves the same.
- `bus_req_ready` low for 5 cycles, then response after 3 → `bus_req_valid` held 6 cycles with fields stable, `mem_resp` exactly once.
- `TIMEOUT=4`, no response → `mem_resp=1`, `mem_err=1` 5 cycles after entering WAIT; the next request completes normally.
- `rst` low during WAIT → all outputs 0 asynchronously, state IDLE; a new read after release completes in 3 cycles.
